// File: rtl/io_port_pkg.sv
// Shared types and command/response word layout for the IO port responder.
package io_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } stateT;

    typedef enum logic {
        RESP_MEM = 1'b0,
        RESP_REG = 1'b1
    } respKindT;

    localparam int DATA_LSB   = 0;
    localparam int DATA_W     = 16;
    localparam int STATUS_LSB = 16;

    // Memory-response layout: status in the upper half, register data in the lower half.
    function automatic logic [31:0] memWord(input logic [15:0] status,
                                            input logic [DATA_W-1:0] data);
        return (32'(status) << STATUS_LSB) | (32'(data) << DATA_LSB);
    endfunction

endpackage

// File: rtl/io_responder_regbank.sv
// Small 16-bit register bank: one write port, one combinational read port, full-bank view.
module io_responder_regbank
    import io_port_pkg::*;
#(
    parameter int  REGCOUNT = 4,
    localparam int ADDRW    = $clog2(REGCOUNT)
) (
    input  logic                             clk,
    input  logic                             async_rst_n,
    input  logic                             wrEn,
    input  logic [ADDRW-1:0]                 wrAddr,
    input  logic [DATA_W-1:0]                wrData,
    input  logic [ADDRW-1:0]                 rdAddr,
    output logic [DATA_W-1:0]                rdData,
    output logic [REGCOUNT-1:0][DATA_W-1:0]  regOut
);

    logic [DATA_W-1:0] bankReg [REGCOUNT];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            bankReg <= '{default: '0};
        end else if (wrEn) begin
            bankReg[wrAddr] <= wrData;
        end
    end

    // Read happens in the same cycle as the write, so a swap sees the pre-write value.
    assign rdData = bankReg[rdAddr];

    for (genvar gi = 0; gi < REGCOUNT; gi++) begin : gRegOut
        assign regOut[gi] = bankReg[gi];
    end

endmodule

// File: rtl/io_port_responder.sv
// Device-side IO command endpoint: executes stores and atomic swaps on the register
// bank and reports memory/register responses, plus unsolicited status-change responses.
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int  PORTBYTEWIDTH = 4,
    parameter int  REGCOUNT      = 4,
    parameter int  ADDR_LSB      = 16,
    localparam int PORTW         = PORTBYTEWIDTH * 8,
    localparam int ADDRW         = $clog2(REGCOUNT)
) (
    input  logic                        clk,
    input  logic                        async_rst_n,
    input  logic                        IOREQ,
    input  logic                        IOCommandEn,
    input  logic                        IOResponseRequested,
    input  logic [3:0]                  IODestRegOut,
    input  logic [PORTW-1:0]            IODataOut,
    input  logic [15:0]                 StatusIn,
    output logic                        IOACK,
    output logic                        IOCommandResponse,
    output logic                        IORegResponseFlag,
    output logic                        IOMemResponseFlag,
    output logic [3:0]                  IODestRegIn,
    output logic [PORTW-1:0]            IODataIn,
    output logic [REGCOUNT-1:0][15:0]   RegOut
);

    stateT              stateReg;
    logic               cmdIsSwapReg;
    logic [3:0]         cmdTagReg;
    logic [ADDRW-1:0]   cmdAddrReg;
    logic [DATA_W-1:0]  cmdDataReg;
    logic [15:0]        lastStatusReg;
    logic [ADDRW-1:0]   lastAddrReg;
    respKindT           respKindReg;
    logic [3:0]         respTagReg;
    logic [PORTW-1:0]   respWordReg;

    logic               cmdPresent;
    logic               consume;
    logic               inResp;
    logic [DATA_W-1:0]  oldValue;
    logic               unusedDataBits;

    assign cmdPresent = IOCommandEn | IOResponseRequested;
    // Handshake is combinational so the controller sees the command taken in the same cycle.
    assign consume    = async_rst_n && (stateReg == IDLE) && cmdPresent && IOREQ;
    assign inResp     = (stateReg == RESP);

    assign IOACK             = consume | inResp;
    assign IOCommandResponse = consume;
    assign IORegResponseFlag = inResp && (respKindReg == RESP_REG);
    assign IOMemResponseFlag = inResp && (respKindReg == RESP_MEM);
    assign IODestRegIn       = inResp ? respTagReg  : '0;
    assign IODataIn          = inResp ? respWordReg : '0;

    assign unusedDataBits = ^IODataOut;

    io_responder_regbank #(
        .REGCOUNT (REGCOUNT)
    ) uRegbank (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .wrEn        (stateReg == EXEC),
        .wrAddr      (cmdAddrReg),
        .wrData      (cmdDataReg),
        .rdAddr      (cmdAddrReg),
        .rdData      (oldValue),
        .regOut      (RegOut)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            stateReg      <= IDLE;
            cmdIsSwapReg  <= 1'b0;
            cmdTagReg     <= '0;
            cmdAddrReg    <= '0;
            cmdDataReg    <= '0;
            lastStatusReg <= '0;
            lastAddrReg   <= '0;
            respKindReg   <= RESP_MEM;
            respTagReg    <= '0;
            respWordReg   <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (consume) begin
                        // Swap wins if both command strobes are raised together.
                        cmdIsSwapReg <= IOResponseRequested;
                        cmdTagReg    <= IODestRegOut;
                        cmdAddrReg   <= IODataOut[ADDR_LSB +: ADDRW];
                        cmdDataReg   <= IODataOut[DATA_LSB +: DATA_W];
                        stateReg     <= EXEC;
                    end else if (!cmdPresent && (StatusIn != lastStatusReg)) begin
                        respWordReg   <= PORTW'(memWord(StatusIn, RegOut[lastAddrReg]));
                        respTagReg    <= '0;
                        respKindReg   <= RESP_MEM;
                        lastStatusReg <= StatusIn;
                        stateReg      <= RESP;
                    end
                end
                EXEC: begin
                    if (cmdIsSwapReg) begin
                        respWordReg <= PORTW'(oldValue);
                        respTagReg  <= cmdTagReg;
                        respKindReg <= RESP_REG;
                    end else begin
                        respWordReg <= PORTW'(memWord(StatusIn, cmdDataReg));
                        respTagReg  <= '0;
                        respKindReg <= RESP_MEM;
                        lastAddrReg <= cmdAddrReg;
                    end
                    stateReg <= RESP;
                end
                RESP: begin
                    if (IOREQ) begin
                        stateReg <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule
